prio_arbiter: RTL and testbench

- Parametrised, registered successor to the combinational 8-input priority encoder.
- Arbitrates N request lines and holds a grant to one requester until that requester releases it.
- Runtime-selectable fixed priority (highest index wins) or round-robin priority.
- Shared-resource arbiter between lab peripherals and a common bus/display.

---
 rtl/prio_arbiter.sv | 142 ++++++++++++++
 tb/tb_prio_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way arbiter. A grant is held until the grantee
// releases it. The priority scheme is selected at run time.
//
// Priority schemes:
//   - Fixed priority: the highest set index of req wins.
//   - Round-robin: a downward scan with wrap that starts at the pointer.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[N]       request lines, one per requester
//   rr_mode      0 = fixed priority, 1 = round-robin
//                (sampled only while arbitrating)
//   rel          the current grantee releases the resource
//   grant_valid  a grant is active
//   grant_idx    index of the grantee; 0 when idle
//   grant_oh     one-hot form of grant_idx; all zeros when idle
//
// All outputs come straight from flops, so there is no combinational path
// from req to the outputs.
module prio_arbiter #(
  parameter int unsigned N  = 8,
  // Derived from N; do not override.
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          rr_mode,
  input  logic          rel,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic [N-1:0]  grant_oh
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        r_state, w_state_d;
  logic [IW-1:0] r_ptr, w_ptr_d;
  logic          r_grant_valid, w_grant_valid_d;
  logic [IW-1:0] r_grant_idx, w_grant_idx_d;
  logic [N-1:0]  r_grant_oh, w_grant_oh_d;

  logic [IW-1:0] w_fix_idx;
  logic [IW-1:0] w_rr_idx;
  logic [IW-1:0] w_sel;
  logic          w_any_req;
  logic          w_eog;
  int            w_pos;

  assign w_any_req = |req;

  // Fixed priority: the last set bit seen in an ascending scan is the highest.
  always_comb begin
    w_fix_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) w_fix_idx = IW'(i);
    end
  end

  // Round-robin: visit the offsets from N-1 down to 0. The smallest offset
  // that has a set request is assigned last, so it wins. Offset k maps to
  // position (ptr - k) mod N. For any N, this wraps from 0 back to N-1.
  always_comb begin
    w_rr_idx = '0;
    w_pos    = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_pos = int'(r_ptr) - k;
      if (w_pos < 0) w_pos = w_pos + int'(N);
      if (req[IW'(w_pos)]) w_rr_idx = IW'(w_pos);
    end
  end

  assign w_sel = rr_mode ? w_rr_idx : w_fix_idx;

  // A grant ends when the grantee releases it or stops requesting.
  assign w_eog = rel | ~req[r_grant_idx];

  always_comb begin
    w_state_d       = r_state;
    w_ptr_d         = r_ptr;
    w_grant_valid_d = r_grant_valid;
    w_grant_idx_d   = r_grant_idx;
    w_grant_oh_d    = r_grant_oh;

    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d       = StGrant;
          w_grant_valid_d = 1'b1;
          w_grant_idx_d   = w_sel;
          w_grant_oh_d    = N'(1) << w_sel;
          w_ptr_d         = (w_sel == '0) ? IW'(N - 1) : w_sel - IW'(1);
        end
      end
      StGrant: begin
        if (w_eog) begin
          if (w_any_req) begin
            // Re-arbitrate among all current requests, including the old
            // grantee. The new grant follows with no idle cycle.
            w_grant_valid_d = 1'b1;
            w_grant_idx_d   = w_sel;
            w_grant_oh_d    = N'(1) << w_sel;
            w_ptr_d         = (w_sel == '0) ? IW'(N - 1) : w_sel - IW'(1);
          end else begin
            w_state_d       = StIdle;
            w_grant_valid_d = 1'b0;
            w_grant_idx_d   = '0;
            w_grant_oh_d    = '0;
          end
        end
      end
      default: begin
        w_state_d       = StIdle;
        w_grant_valid_d = 1'b0;
        w_grant_idx_d   = '0;
        w_grant_oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_ptr         <= IW'(N - 1);
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_grant_oh    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_ptr         <= w_ptr_d;
      r_grant_valid <= w_grant_valid_d;
      r_grant_idx   <= w_grant_idx_d;
      r_grant_oh    <= w_grant_oh_d;
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign grant_oh    = r_grant_oh;

endmodule

// File: tb/tb_prio_arbiter.sv
module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req = '0;
  logic       rr_mode = 1'b0;
  logic       rel = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;

  logic [4:0] req5 = '0;
  logic       rr5 = 1'b0;
  logic       rel5 = 1'b0;
  logic       gv5;
  logic [2:0] gi5;
  logic [4:0] go5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_arbiter #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rr_mode     (rr_mode),
    .rel         (rel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh)
  );

  prio_arbiter #(.N(5)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req5),
    .rr_mode     (rr5),
    .rel         (rel5),
    .grant_valid (gv5),
    .grant_idx   (gi5),
    .grant_oh    (go5)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; rel = 1'b0; req5 = '0; rel5 = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({grant_valid, grant_idx, grant_oh} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got v=%b idx=%0d oh=%b want 0/0/0",
               grant_valid, grant_idx, grant_oh);
    end
    rst_n = 1'b1;
    tick();
    req = 8'b0010_0100; rr_mode = 1'b0;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5 || grant_oh !== 8'b0010_0000) begin
      failures++;
      $display("FAIL first_grant got v=%b idx=%0d oh=%b want 1/5/00100000",
               grant_valid, grant_idx, grant_oh);
    end
    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant_valid, grant_idx, grant_oh} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset got v=%b idx=%0d oh=%b want 0/0/0",
               grant_valid, grant_idx, grant_oh);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held got v=%b want 0", grant_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin
      failures++;
      $display("FAIL resume_after_reset got v=%b idx=%0d want 1/5", grant_valid, grant_idx);
    end
    req = '0;
    tick();
    checks++;
    if ({grant_valid, grant_idx, grant_oh} !== 12'h000) begin
      failures++;
      $display("FAIL back_to_idle got v=%b idx=%0d oh=%b want 0/0/0",
               grant_valid, grant_idx, grant_oh);
    end
  endtask

  task automatic test_fixed_exhaustive();
    int exp;
    do_reset();
    rr_mode = 1'b0;
    req = '0;
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_req0 got v=%b want 0", grant_valid);
    end
    for (int r = 1; r < 256; r++) begin
      req = 8'(r);
      exp = 0;
      for (int b = 0; b < 8; b++) if (req[b]) exp = b;
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(exp) || grant_oh !== (8'd1 << exp)) begin
        failures++;
        $display("FAIL fixed_req%0d got v=%b idx=%0d oh=%b want 1/%0d", r,
                 grant_valid, grant_idx, grant_oh, exp);
      end
      req = '0;
      tick();
      checks++;
      if (grant_valid !== 1'b0) begin
        failures++;
        $display("FAIL fixed_release%0d got v=%b want 0", r, grant_valid);
      end
    end
  endtask

  task automatic test_rr_all();
    int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    do_reset();
    rr_mode = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      rel = (i > 0);
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(exp_seq[i]) ||
          grant_oh !== (8'd1 << exp_seq[i])) begin
        failures++;
        $display("FAIL rr_all_step%0d got v=%b idx=%0d want 1/%0d", i,
                 grant_valid, grant_idx, exp_seq[i]);
      end
    end
    rel = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_rr_fairness();
    int exp_rr[4] = '{7, 0, 7, 0};
    do_reset();
    rr_mode = 1'b1; req = 8'b1000_0001; rel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'(exp_rr[i])) begin
        failures++;
        $display("FAIL rr_fair_step%0d got v=%b idx=%0d want 1/%0d", i,
                 grant_valid, grant_idx, exp_rr[i]);
      end
    end
    do_reset();
    rr_mode = 1'b0; req = 8'b1000_0001; rel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd7) begin
        failures++;
        $display("FAIL fixed_fair_step%0d got v=%b idx=%0d want 1/7", i,
                 grant_valid, grant_idx);
      end
    end
    rel = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_grantee_drop();
    do_reset();
    rr_mode = 1'b0; req = 8'b0000_1000;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd3) begin
      failures++;
      $display("FAIL drop_grant3 got v=%b idx=%0d want 1/3", grant_valid, grant_idx);
    end
    // Higher requesters and a mode change are ignored while the grant holds.
    req = 8'b1000_1010; rr_mode = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd3 || grant_oh !== 8'b0000_1000) begin
      failures++;
      $display("FAIL drop_hold got v=%b idx=%0d oh=%b want 1/3/00001000",
               grant_valid, grant_idx, grant_oh);
    end
    rr_mode = 1'b0; req = 8'b0000_0010;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd1 || grant_oh !== 8'b0000_0010) begin
      failures++;
      $display("FAIL drop_to1 got v=%b idx=%0d oh=%b want 1/1/00000010",
               grant_valid, grant_idx, grant_oh);
    end
    req = '0;
    tick();
    checks++;
    if ({grant_valid, grant_idx, grant_oh} !== 12'h000) begin
      failures++;
      $display("FAIL drop_idle got v=%b idx=%0d oh=%b want 0/0/0",
               grant_valid, grant_idx, grant_oh);
    end
  endtask

  task automatic test_rel_cases();
    do_reset();
    rr_mode = 1'b0; req = '0; rel = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL rel_idle got v=%b want 0", grant_valid);
    end
    req = 8'b0001_0000;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd4) begin
      failures++;
      $display("FAIL rel_with_req got v=%b idx=%0d want 1/4", grant_valid, grant_idx);
    end
    // The old grantee is still the highest requester, so it is granted again.
    req = 8'b0001_0001;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd4) begin
      failures++;
      $display("FAIL rel_regrant got v=%b idx=%0d want 1/4", grant_valid, grant_idx);
    end
    req = 8'b0000_0001;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_oh !== 8'b0000_0001) begin
      failures++;
      $display("FAIL rel_to0 got v=%b idx=%0d oh=%b want 1/0/00000001",
               grant_valid, grant_idx, grant_oh);
    end
    rel = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_n5_wrap();
    int exp5[10] = '{4, 0, 4, 0, 4, 3, 2, 1, 0, 4};
    do_reset();
    rr5 = 1'b1; rel5 = 1'b1; req5 = 5'b10001;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) req5 = 5'b11111;
      tick();
      checks++;
      if (gv5 !== 1'b1 || gi5 !== 3'(exp5[i]) || go5 !== (5'd1 << exp5[i]) || gi5 > 3'd4) begin
        failures++;
        $display("FAIL n5_step%0d got v=%b idx=%0d oh=%b want 1/%0d", i,
                 gv5, gi5, go5, exp5[i]);
      end
    end
    rel5 = 1'b0; req5 = '0;
    tick();
    checks++;
    if (gv5 !== 1'b0 || go5 !== 5'b0) begin
      failures++;
      $display("FAIL n5_idle got v=%b oh=%b want 0/00000", gv5, go5);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_exhaustive();
    test_rr_all();
    test_rr_fairness();
    test_grantee_drop();
    test_rel_cases();
    test_n5_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
